// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode values, instruction field
// positions and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_W     = 8;
    localparam int OPCODE_W    = 3;
    localparam int OPERAND_W   = 5;
    localparam int OPCODE_MSB  = 7;
    localparam int OPCODE_LSB  = 5;
    localparam int OPERAND_MSB = 4;
    localparam int OPERAND_LSB = 0;

    localparam logic [OPCODE_W-1:0] OP_HLT    = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_SKZ    = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ALU_LO = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_ALU_HI = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_STO    = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_JMP    = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4,
        ST_PAUSE = 3'd5
    } fetch_state_t;

    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

endpackage

// File: rtl/pc_next_unit.sv
// Next program counter selection: sequential, skip-if-zero or jump target.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]    pc_i,
    input  logic [OPCODE_W-1:0]  opcode_i,
    input  logic [OPERAND_W-1:0] operand_i,
    input  logic                 zero_i,
    output logic [ADDR_W-1:0]    pc_next_o
);

    always_comb begin
        pc_next_o = pc_i + ADDR_W'(1);
        if (opcode_i == OP_JMP) begin
            pc_next_o = ADDR_W'(operand_i);
        end else if ((opcode_i == OP_SKZ) && zero_i) begin
            pc_next_o = pc_i + ADDR_W'(2);
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: fetches, issues opcodes with an enable
// pulse and maintains the PC. Define SINGLE_STEP_EN to add step_i and PAUSE.
module instr_fetch_seq
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_i,
    input  logic                 zero_i,
`ifdef SINGLE_STEP_EN
    input  logic                 step_i,
`endif
    input  logic                 instr_valid_i,
    input  logic [INSTR_W-1:0]   instr_data_i,
    output logic                 instr_req_o,
    output logic [ADDR_W-1:0]    instr_addr_o,
    output logic [OPCODE_W-1:0]  opcode_o,
    output logic [OPERAND_W-1:0] operand_o,
    output logic                 en_o,
    output logic [ADDR_W-1:0]    pc_o,
    output logic                 halted_o
);

    fetch_state_t        state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [INSTR_W-1:0]  ir_q;
    logic                zero_q;
    logic                req_q;
    logic                en_q;
    logic                halted_q;

    pc_next_unit #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc_i      (pc_q),
        .opcode_i  (ir_q[OPCODE_MSB:OPCODE_LSB]),
        .operand_i (ir_q[OPERAND_MSB:OPERAND_LSB]),
        .zero_i    (zero_q),
        .pc_next_o (pc_d)
    );

    // Output flags are registered alongside the state they belong to, so the
    // async reset clears them in the same instant as the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            zero_q   <= 1'b0;
            req_q    <= 1'b0;
            en_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pc_q <= RESET_PC;
                    if (run_i) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (instr_valid_i) begin
                        ir_q    <= instr_data_i;
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b0;
                        en_q    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    zero_q  <= zero_i;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc_q <= pc_d;
                    if (ir_q[OPCODE_MSB:OPCODE_LSB] == OP_HLT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (!run_i) begin
                        state_q <= ST_IDLE;
                        pc_q    <= RESET_PC;
                    end else begin
`ifdef SINGLE_STEP_EN
                        state_q <= ST_PAUSE;
`else
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
`endif
                    end
                end
                ST_HALT: begin
                    if (!run_i) begin
                        state_q  <= ST_IDLE;
                        halted_q <= 1'b0;
                        pc_q     <= RESET_PC;
                    end
                end
`ifdef SINGLE_STEP_EN
                ST_PAUSE: begin
                    if (!run_i) begin
                        state_q <= ST_IDLE;
                        pc_q    <= RESET_PC;
                    end else if (step_i) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    req_q    <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_req_o  = req_q;
    assign instr_addr_o = pc_q;
    assign opcode_o     = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign operand_o    = ir_q[OPERAND_MSB:OPERAND_LSB];
    assign en_o         = en_q;
    assign pc_o         = pc_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed program-flow cases, async
// reset aborts, then randomized instructions against a PC reference model.
module tb_instr_fetch_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       zero;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_req;
    logic [4:0] instr_addr;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       en;
    logic [4:0] pc;
    logic       halted;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_pc   = 0;

    instr_fetch_seq #(.ADDR_W(5), .RESET_PC(5'd0)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .run_i         (run),
        .zero_i        (zero),
`ifdef SINGLE_STEP_EN
        .step_i        (step),
`endif
        .instr_valid_i (instr_valid),
        .instr_data_i  (instr_data),
        .instr_req_o   (instr_req),
        .instr_addr_o  (instr_addr),
        .opcode_o      (opcode),
        .operand_o     (operand),
        .en_o          (en),
        .pc_o          (pc),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    instr_req,  0);
        check({tag, "_addr"},   instr_addr, 0);
        check({tag, "_opcode"}, opcode,     0);
        check({tag, "_operand"}, operand,   0);
        check({tag, "_en"},     en,         0);
        check({tag, "_pc"},     pc,         0);
        check({tag, "_halted"}, halted,     0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!instr_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", (n < 50), 1);
    endtask

    // Executes one instruction from the memory side; called on a negedge.
    task automatic do_instr(input logic [7:0] data, input logic z, input int waits,
                            input logic drop_run);
        int op;
        int opd;
        int nxt;
        wait_req();
        check("addr", instr_addr, exp_pc);
        for (int i = 0; i < waits; i++) begin
            instr_valid = 1'b0;
            instr_data  = 8'($urandom);
            @(negedge clk);
            check("req_hold",  instr_req,  1);
            check("addr_hold", instr_addr, exp_pc);
            check("en_wait",   en,         0);
        end
        instr_valid = 1'b1;
        instr_data  = data;
        @(negedge clk);
        // ISSUE: valid now is garbage and must be ignored
        instr_valid = 1'($urandom);
        instr_data  = 8'($urandom);
        zero        = z;
        check("en_issue", en,      1);
        check("opcode",   opcode,  data[7:5]);
        check("operand",  operand, data[4:0]);
        check("req_issue", instr_req, 0);
        op  = int'(data[7:5]);
        opd = int'(data[4:0]);
        if (op == 7)
            nxt = opd;
        else if (op == 1 && z)
            nxt = (exp_pc + 2) % 32;
        else
            nxt = (exp_pc + 1) % 32;
        @(negedge clk);
        // EXEC
        instr_valid = 1'b0;
        zero        = 1'($urandom);
        check("en_exec",     en,     0);
        check("opcode_hold", opcode, data[7:5]);
        if (drop_run) run = 1'b0;
        @(negedge clk);
        if (op == 0) begin
            check("halted",    halted,    1);
            check("halt_pc",   pc,        nxt);
            check("halt_req",  instr_req, 0);
            check("halt_en",   en,        0);
            if (!drop_run) begin
                @(negedge clk);
                check("halt_stay", halted, 1);
                check("halt_pc_frozen", pc, nxt);
                run = 1'b0;
            end
            @(negedge clk);
            check("idle_halted", halted,    0);
            check("idle_pc",     pc,        0);
            check("idle_req",    instr_req, 0);
            run    = 1'b1;
            exp_pc = 0;
        end else if (drop_run) begin
            check("drop_pc",  pc,        0);
            check("drop_req", instr_req, 0);
            run    = 1'b1;
            exp_pc = 0;
        end else begin
            check("next_pc", pc, nxt);
`ifndef SINGLE_STEP_EN
            check("refetch_req", instr_req, 1);
`endif
            exp_pc = nxt;
        end
        $display("txn data=%02h zero=%0d waits=%0d drop=%0d next_pc=%0d", data, z, waits,
                 drop_run, exp_pc);
    endtask

    localparam int N_DIR = 15;
    logic [7:0] dir_data  [N_DIR] = '{8'h45, 8'hE4, 8'h20, 8'hE4, 8'h20, 8'hFF, 8'h20, 8'hE3,
                                      8'hE7, 8'h00, 8'hFF, 8'h45, 8'hFE, 8'h3A, 8'hC9};
    logic       dir_zero  [N_DIR] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
    int         dir_waits [N_DIR] = '{0, 3, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst         = 1'b1;
        run         = 1'b0;
        zero        = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_run_req", instr_req, 0);
        run = 1'b1;

        for (int i = 0; i < N_DIR; i++)
            do_instr(dir_data[i], dir_zero[i], dir_waits[i], 1'b0);

        // Reset during FETCH
        wait_req();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_fetch");
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = 0;

        // Reset during ISSUE
        wait_req();
        instr_valid = 1'b1;
        instr_data  = 8'h45;
        @(posedge clk);
        #2 check("pre_rst_en", en, 1);
        rst = 1'b1;
        #1 check_reset_outputs("rst_issue");
        instr_valid = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = 0;

        for (int i = 0; i < 60; i++) begin
            do_instr(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
